// File: rtl/dwell_counter.sv
// dwell_counter: up/down counter with programmable top, terminal dwell and synchronous load
module dwell_counter #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode_down,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   top,
    input  logic [DWELL_W-1:0] dwell_cycles,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               dwelling,
    output logic [DWELL_W-1:0] dwell_left
);
    localparam logic [0:0] COUNT = 1'b0;
    localparam logic [0:0] DWELL = 1'b1;
    logic [0:0]       state;
    logic             term;
    logic [WIDTH-1:0] clamp, wrap;
    always_comb begin
        term  = mode_down ? (count == '0) : (count >= top);
        clamp = (load_val > top) ? top : load_val;
        wrap  = mode_down ? top : '0;
    end
    assign dwelling = state == DWELL;
    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            tc         <= 1'b0;
            dwell_left <= '0;
            state      <= COUNT;
        end else if (load) begin
            count      <= clamp;
            tc         <= 1'b0;
            dwell_left <= '0;
            state      <= COUNT;
        end else if (state == DWELL) begin
            tc <= 1'b0;
            if (dwell_left == DWELL_W'(1)) begin
                count      <= wrap;
                dwell_left <= '0;
                state      <= COUNT;
            end else begin
                dwell_left <= dwell_left - DWELL_W'(1);
            end
        end else if (en) begin
            tc <= term;
            if (!term)
                count <= mode_down ? count - WIDTH'(1) : count + WIDTH'(1);
            else if (dwell_cycles == '0)
                count <= wrap;
            else begin
                dwell_left <= dwell_cycles;
                state      <= DWELL;
            end
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dwell_counter.sv
// tb_dwell_counter: directed checks of dwell_counter at WIDTH=8 and WIDTH=4
module tb_dwell_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en, mode_down, load;
    logic [7:0] load_val, top, count;
    logic [3:0] dwell_cycles, dwell_left;
    logic       tc, dwelling;
    logic       en4, mode_down4, load4;
    logic [3:0] load_val4, top4, count4, dwell_cycles4, dwell_left4;
    logic       tc4, dwelling4;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dwell_counter #(.WIDTH(8), .DWELL_W(4)) u8 (
        .clk(clk), .rst(rst), .en(en), .mode_down(mode_down), .load(load),
        .load_val(load_val), .top(top), .dwell_cycles(dwell_cycles),
        .count(count), .tc(tc), .dwelling(dwelling), .dwell_left(dwell_left)
    );

    dwell_counter #(.WIDTH(4), .DWELL_W(4)) u4 (
        .clk(clk), .rst(rst), .en(en4), .mode_down(mode_down4), .load(load4),
        .load_val(load_val4), .top(top4), .dwell_cycles(dwell_cycles4),
        .count(count4), .tc(tc4), .dwelling(dwelling4), .dwell_left(dwell_left4)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input int c, input int t, input int d, input int dl);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".tc"}, int'(tc), t);
        chk({tag, ".dwelling"}, int'(dwelling), d);
        chk({tag, ".dwell_left"}, int'(dwell_left), dl);
    endtask

    task automatic chk4(input string tag, input int c, input int t);
        chk({tag, ".count4"}, int'(count4), c);
        chk({tag, ".tc4"}, int'(tc4), t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1'b1; mode_down = 1'b0; load = 1'b1; load_val = 8'd5; top = 8'd9; dwell_cycles = 4'd3;
        en4 = 1'b1; mode_down4 = 1'b0; load4 = 1'b1; load_val4 = 4'd5; top4 = 4'd15; dwell_cycles4 = 4'd0;
        tick(); tick();
        chk8("reset", 0, 0, 0, 0);
        chk4("reset4", 0, 0);
        chk("reset4.dwelling", int'(dwelling4), 0);

        // up to 9 with a 3-cycle dwell
        rst = 1'b1; load = 1'b0; en4 = 1'b0; load4 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk8($sformatf("up%0d", k), k, 0, 0, 0);
        end
        tick(); chk8("dwell3", 9, 1, 1, 3);
        tick(); chk8("dwell2", 9, 0, 1, 2);
        tick(); chk8("dwell1", 9, 0, 1, 1);
        tick(); chk8("dwell_end", 0, 0, 0, 0);
        tick(); chk8("resume", 1, 0, 0, 0);

        // down from 2, top=5, no dwell
        load = 1'b1; load_val = 8'd2; top = 8'd5; dwell_cycles = 4'd0; mode_down = 1'b1;
        tick(); chk8("dn_load", 2, 0, 0, 0);
        load = 1'b0;
        tick(); chk8("dn1", 1, 0, 0, 0);
        tick(); chk8("dn0", 0, 0, 0, 0);
        tick(); chk8("dn_wrap", 5, 1, 0, 0);
        tick(); chk8("dn4", 4, 0, 0, 0);
        en = 1'b0;
        tick(); chk8("freeze1", 4, 0, 0, 0);
        tick(); chk8("freeze2", 4, 0, 0, 0);
        en = 1'b1;
        tick(); chk8("dn3", 3, 0, 0, 0);

        // clamped load, then load aborting a dwell
        mode_down = 1'b0; load = 1'b1; load_val = 8'd200; top = 8'd50; dwell_cycles = 4'd3;
        tick(); chk8("clamp", 50, 0, 0, 0);
        load = 1'b0;
        tick(); chk8("top50_dwell", 50, 1, 1, 3);
        tick(); chk8("top50_dwell2", 50, 0, 1, 2);
        load = 1'b1; load_val = 8'd7;
        tick(); chk8("abort", 7, 0, 0, 0);

        // reset in the middle of a dwell
        load = 1'b0; top = 8'd7;
        tick(); chk8("pre_rst3", 7, 1, 1, 3);
        top = 8'd100; dwell_cycles = 4'd9;
        tick(); chk8("pre_rst2", 7, 0, 1, 2);
        rst = 1'b0;
        tick(); chk8("rst_dwell", 0, 0, 0, 0);

        // top=0 up: terminal every enabled cycle
        rst = 1'b1; top = 8'd0; dwell_cycles = 4'd0;
        tick(); chk8("top0_a", 0, 1, 0, 0);
        tick(); chk8("top0_b", 0, 1, 0, 0);
        en = 1'b0;

        // WIDTH=4 natural rollover and lowered top
        load4 = 1'b1; load_val4 = 4'd14; top4 = 4'd15; en4 = 1'b1;
        tick(); chk4("w4_14", 14, 0);
        load4 = 1'b0;
        tick(); chk4("w4_15", 15, 0);
        tick(); chk4("w4_roll", 0, 1);
        tick(); chk4("w4_1", 1, 0);
        load4 = 1'b1; load_val4 = 4'd10;
        tick(); chk4("w4_10", 10, 0);
        load4 = 1'b0; top4 = 4'd3;
        tick(); chk4("w4_lowtop", 0, 1);
        tick(); chk4("w4_after", 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
